data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface: decodes the word address, write data and write enable driven by the pipelined ARM core, and returns read data.
- Contains three regions: general data RAM, a camera frame buffer, and a small memory-mapped I/O block.
- A camera capture state machine streams pixels into the frame buffer over a valid/ready handshake.
- Sits beside the core at top level; it is the memory the core's memory stage talks to.

---
 rtl/mem_map_pkg.sv | 33 +++
 rtl/cam_capture_fsm.sv | 117 +++++++++++
 rtl/data_mem_responder.sv | 108 ++++++++++
 tb/tb_data_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// ============================================================================
// Module : mem_map_pkg
// Brief  : Address map, CONTROL bit positions and capture state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_map_pkg;

    localparam logic [31:0] FB_BASE_DEFAULT = 32'h0001_0000;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0002_0000;
    localparam logic [31:0] STATUS_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] CONTROL_OFFSET  = 32'h0000_0004;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_ACK_BIT = 1;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_WAIT_SOF = 2'd1,
        CAP_CAPTURE  = 2'd2,
        CAP_DONE     = 2'd3
    } cap_state_t;

    function automatic logic [31:0] status_word(input logic       frame_ready,
                                                input logic [1:0] state,
                                                input logic [7:0] frame_count);
        return {16'h0000, frame_count, 4'h0, 1'b0, state, frame_ready};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_capture_fsm.sv
// ============================================================================
// Module : cam_capture_fsm
// Brief  : Camera capture sequencer; produces frame-buffer writes from pixels.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cam_capture_fsm
    import mem_map_pkg::*;
#(
    parameter int FB_WORDS = 256,
    parameter int FB_AW    = $clog2(FB_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_capture_en,
    input  logic             i_ack,
    input  logic             i_cpu_fb_wr,
    input  logic             i_cam_valid,
    input  logic [7:0]       i_cam_pixel,
    input  logic             i_cam_sof,
    output logic             o_cam_ready,
    output logic             o_fb_we,
    output logic [FB_AW-1:0] o_fb_idx,
    output logic [31:0]      o_fb_data,
    output logic [1:0]       o_state,
    output logic             o_frame_ready,
    output logic [7:0]       o_frame_count,
    output logic             o_frame_irq
);

    localparam logic [FB_AW-1:0] c_LAST = FB_AW'(FB_WORDS - 1);
    localparam logic [FB_AW-1:0] c_ONE  = FB_AW'(1);

    cap_state_t       r_state, w_state_nxt;
    logic [FB_AW-1:0] r_idx, w_idx_nxt, w_fb_idx;
    logic             r_frame_ready, r_frame_irq;
    logic [7:0]       r_frame_count;
    logic             w_busy, w_ready, w_accept, w_fb_we, w_set, w_fr_held;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fb_we     = 1'b0;
        w_fb_idx    = r_idx;
        w_set       = 1'b0;
        w_busy      = (r_state == CAP_WAIT_SOF) || (r_state == CAP_CAPTURE);
        w_ready     = w_busy && !i_cpu_fb_wr;
        w_accept    = w_ready && i_cam_valid;
        w_fr_held   = r_frame_ready && !i_ack;
        case (r_state)
            CAP_IDLE: begin
                if (i_capture_en) w_state_nxt = CAP_WAIT_SOF;
            end
            CAP_WAIT_SOF: begin
                if (w_accept && i_cam_sof) begin
                    w_fb_we     = 1'b1;
                    w_fb_idx    = '0;
                    w_idx_nxt   = c_ONE;
                    w_state_nxt = CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                if (w_accept) begin
                    w_fb_we = 1'b1;
                    if (i_cam_sof) begin
                        // A new start-of-frame silently abandons the partial frame
                        w_fb_idx  = '0;
                        w_idx_nxt = c_ONE;
                    end else if (r_idx == c_LAST) begin
                        w_set       = 1'b1;
                        w_state_nxt = CAP_DONE;
                    end else begin
                        w_idx_nxt = r_idx + c_ONE;
                    end
                end
            end
            CAP_DONE: begin
                if (!w_fr_held) w_state_nxt = i_capture_en ? CAP_WAIT_SOF : CAP_IDLE;
            end
            default: w_state_nxt = CAP_IDLE;
        endcase
        // Disabling capture aborts the frame; the accepted beat is still written
        if (w_busy && !i_capture_en) begin
            w_state_nxt = CAP_IDLE;
            w_set       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CAP_IDLE;
            r_idx         <= '0;
            r_frame_ready <= 1'b0;
            r_frame_count <= 8'd0;
            r_frame_irq   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_ready <= w_set || w_fr_held;
            r_frame_count <= r_frame_count + {7'd0, w_set};
            r_frame_irq   <= w_set;
        end
    end

    assign o_cam_ready   = w_ready;
    assign o_fb_we       = w_fb_we;
    assign o_fb_idx      = w_fb_idx;
    assign o_fb_data     = {24'h000000, i_cam_pixel};
    assign o_state       = r_state;
    assign o_frame_ready = r_frame_ready;
    assign o_frame_count = r_frame_count;
    assign o_frame_irq   = r_frame_irq;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : CPU data-memory responder: RAM, camera frame buffer and I/O regs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] FB_BASE   = FB_BASE_DEFAULT,
    parameter int          FB_WORDS  = 256,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    input  logic        cam_valid,
    output logic        cam_ready,
    input  logic [7:0]  cam_pixel,
    input  logic        cam_sof,
    output logic        frame_irq
);

    localparam int          c_RAM_AW     = $clog2(RAM_WORDS);
    localparam int          c_FB_AW      = $clog2(FB_WORDS);
    localparam logic [31:0] c_RAM_END    = 32'(RAM_WORDS * 4);
    localparam logic [31:0] c_FB_END     = FB_BASE + 32'(FB_WORDS * 4);
    localparam logic [31:0] c_STATUS_ADR = IO_BASE + STATUS_OFFSET;
    localparam logic [31:0] c_CTRL_ADR   = IO_BASE + CONTROL_OFFSET;

    logic [31:0]         r_ram [RAM_WORDS];
    logic [31:0]         r_fb  [FB_WORDS];
    logic                r_capture_en;

    logic                w_ram_hit, w_fb_hit, w_status_hit, w_ctrl_hit;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic [c_FB_AW-1:0]  w_fb_idx, w_cam_idx;
    logic                w_cpu_fb_wr, w_ctrl_wr, w_ack, w_capture_en_nxt;
    logic                w_cam_we, w_frame_ready;
    logic [31:0]         w_cam_data;
    logic [1:0]          w_state;
    logic [7:0]          w_frame_count;

    assign w_ram_hit    = addr < c_RAM_END;
    assign w_fb_hit     = (addr >= FB_BASE) && (addr < c_FB_END);
    assign w_status_hit = addr[31:2] == c_STATUS_ADR[31:2];
    assign w_ctrl_hit   = addr[31:2] == c_CTRL_ADR[31:2];
    assign w_ram_idx    = addr[2 +: c_RAM_AW];
    assign w_fb_idx     = c_FB_AW'(addr[31:2] - FB_BASE[31:2]);

    assign w_cpu_fb_wr      = write_enable && w_fb_hit;
    assign w_ctrl_wr        = write_enable && w_ctrl_hit;
    assign w_ack            = w_ctrl_wr && write_data[CTRL_ACK_BIT];
    assign w_capture_en_nxt = w_ctrl_wr ? write_data[CTRL_EN_BIT] : r_capture_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_capture_en <= 1'b0;
        else        r_capture_en <= w_capture_en_nxt;
    end

    cam_capture_fsm #(
        .FB_WORDS (FB_WORDS),
        .FB_AW    (c_FB_AW)
    ) u_cap (
        .clk           (clk),
        .rst_n         (reset),
        .i_capture_en  (w_capture_en_nxt),
        .i_ack         (w_ack),
        .i_cpu_fb_wr   (w_cpu_fb_wr),
        .i_cam_valid   (cam_valid),
        .i_cam_pixel   (cam_pixel),
        .i_cam_sof     (cam_sof),
        .o_cam_ready   (cam_ready),
        .o_fb_we       (w_cam_we),
        .o_fb_idx      (w_cam_idx),
        .o_fb_data     (w_cam_data),
        .o_state       (w_state),
        .o_frame_ready (w_frame_ready),
        .o_frame_count (w_frame_count),
        .o_frame_irq   (frame_irq)
    );

    always_ff @(posedge clk) begin
        if (write_enable && w_ram_hit) r_ram[w_ram_idx] <= write_data;
    end

    // Camera is held off whenever the CPU stores to the FB, so one port suffices
    always_ff @(posedge clk) begin
        if (w_cpu_fb_wr)   r_fb[w_fb_idx]  <= write_data;
        else if (w_cam_we) r_fb[w_cam_idx] <= w_cam_data;
    end

    always_comb begin
        read_data = 32'h0000_0000;
        if (w_ram_hit)         read_data = r_ram[w_ram_idx];
        else if (w_fb_hit)     read_data = r_fb[w_fb_idx];
        else if (w_status_hit) read_data = status_word(w_frame_ready, w_state, w_frame_count);
        else if (w_ctrl_hit)   read_data = {31'h0, r_capture_en};
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Self-checking bench for data_mem_responder with a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int          RAMW = 1024;
    localparam int          FBW  = 256;
    localparam logic [31:0] FBB  = 32'h0001_0000;
    localparam logic [31:0] STA  = 32'h0002_0000;
    localparam logic [31:0] CTL  = 32'h0002_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, write_data = '0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic        cam_valid = 1'b0, cam_ready, cam_sof = 1'b0, frame_irq;
    logic [7:0]  cam_pixel = '0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data),
        .cam_valid    (cam_valid),
        .cam_ready    (cam_ready),
        .cam_pixel    (cam_pixel),
        .cam_sof      (cam_sof),
        .frame_irq    (frame_irq)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: memories plus the capture sequencer's visible state
    logic [31:0] m_ram [RAMW];
    bit          m_ram_v [RAMW];
    logic [31:0] m_fb [FBW];
    bit          m_fb_v [FBW];
    int          ms, midx, mcnt;
    bit          mfr, men, mirq;

    logic [31:0] s_rd;
    logic        s_ready, s_irq;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        bit          check;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        ms = 0; midx = 0; mcnt = 0; mfr = 0; men = 0; mirq = 0;
    endfunction

    // One clock cycle: drive, check against the model, advance model and DUT
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic v, input logic [7:0] pix, input logic sof);
        bit ramh, fbh, known, en_n, ack, acc, set;
        int ri, fi, nms;
        logic [31:0] erd;
        logic eready;
        write_enable = we; addr = a; write_data = wd;
        cam_valid = v; cam_pixel = pix; cam_sof = sof;
        #1;
        ramh = a < 32'(RAMW * 4);
        fbh  = (a >= FBB) && (a < FBB + 32'(FBW * 4));
        ri = 0; fi = 0; known = 1; erd = '0;
        if (ramh) begin
            ri = int'(a >> 2); erd = m_ram[ri]; known = m_ram_v[ri];
        end else if (fbh) begin
            fi = int'((a - FBB) >> 2); erd = m_fb[fi]; known = m_fb_v[fi];
        end else if (a[31:2] == STA[31:2]) begin
            erd = {16'h0, 8'(mcnt), 4'h0, 3'(ms), mfr};
        end else if (a[31:2] == CTL[31:2]) begin
            erd = {31'h0, men};
        end
        eready = (ms == 1 || ms == 2) && !(we && fbh);
        s_rd = read_data; s_ready = cam_ready; s_irq = frame_irq;
        if (known) chk("read_data", read_data, erd);
        chk("cam_ready", {31'h0, cam_ready}, {31'h0, eready});
        chk("frame_irq", {31'h0, frame_irq}, {31'h0, mirq});

        en_n = (we && a[31:2] == CTL[31:2]) ? wd[0] : men;
        ack  = we && a[31:2] == CTL[31:2] && wd[1];
        acc  = v && eready;
        set  = 0;
        nms  = ms;
        if (we && ramh) begin m_ram[ri] = wd; m_ram_v[ri] = 1; end
        if (we && fbh)  begin m_fb[fi] = wd;  m_fb_v[fi] = 1;  end
        if (acc && (ms == 1 || ms == 2)) begin
            if (sof) begin
                m_fb[0] = {24'h0, pix}; m_fb_v[0] = 1; midx = 1; nms = 2;
            end else if (ms == 2) begin
                m_fb[midx] = {24'h0, pix}; m_fb_v[midx] = 1;
                if (midx == FBW - 1) begin set = 1; nms = 3; end
                else midx++;
            end
        end
        if (ms == 0 && en_n) nms = 1;
        if (ms == 3 && !(mfr && !ack)) nms = en_n ? 1 : 0;
        if ((ms == 1 || ms == 2) && !en_n) begin nms = 0; set = 0; end
        mfr  = set ? 1'b1 : (mfr && !ack);
        mcnt = (mcnt + int'(set)) % 256;
        mirq = set;
        men  = en_n;
        ms   = nms;
        @(posedge clk); #1;
    endtask

    task automatic idle_read(input logic [31:0] a);
        cycle(1'b0, a, 32'h0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic beat(input logic [7:0] pix, input logic sof);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, pix, sof);
    endtask

    initial begin
        int irqs;
        model_reset();
        for (int i = 0; i < RAMW; i++) m_ram_v[i] = 0;
        for (int i = 0; i < FBW; i++)  m_fb_v[i] = 0;

        tbl[0]  = '{1'b1, 32'h0000_0040, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h0003_0000, 32'h0,        1'b1, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_0047, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0044, 32'h0,        1'b1, 32'hCAFEF00D};
        tbl[5]  = '{1'b1, 32'h0003_0000, 32'h1234_5678, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0003_0000, 32'h0,        1'b1, 32'h0};
        tbl[7]  = '{1'b0, CTL,           32'h0,        1'b1, 32'h0};
        tbl[8]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_0001, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0FFD, 32'h0,        1'b1, 32'hA5A5_0001};
        tbl[10] = '{1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h0};
        tbl[11] = '{1'b1, FBB + 32'h3FC, 32'h0BAD_F00D, 1'b0, 32'h0};
        tbl[12] = '{1'b0, FBB + 32'h3FC, 32'h0,        1'b1, 32'h0BAD_F00D};
        tbl[13] = '{1'b0, FBB + 32'h400, 32'h0,        1'b1, 32'h0};

        // Reset state
        addr = STA;
        #12;
        chk("rst_cam_ready", {31'h0, cam_ready}, 32'h0);
        chk("rst_frame_irq", {31'h0, frame_irq}, 32'h0);
        chk("rst_status", read_data, 32'h0);
        #4 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].we, tbl[i].a, tbl[i].wd, 1'b0, 8'h00, 1'b0);
            if (tbl[i].check) chk("table_read", s_rd, tbl[i].exp);
        end

        // Full frame capture preceded by three discarded beats
        cycle(1'b1, CTL, 32'h1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'hF0 + 8'(i), 1'b0);
        irqs = 0;
        for (int k = 0; k < FBW; k++) begin
            beat(8'(k), k == 0);
            irqs += int'(s_irq);
        end
        cycle(1'b0, STA, 32'h0, 1'b1, 8'h00, 1'b0);
        irqs += int'(s_irq);
        chk("done_status", s_rd, 32'h0000_0107);
        cycle(1'b0, STA, 32'h0, 1'b1, 8'h00, 1'b0);
        irqs += int'(s_irq);
        chk("done_cam_ready", {31'h0, s_ready}, 32'h0);
        chk("irq_pulses", irqs, 32'd1);
        for (int k = 0; k < FBW; k++) begin
            idle_read(FBB + 32'(4 * k));
            chk("fb_pixel", s_rd, 32'(k));
        end

        // Ack plus enable from DONE
        cycle(1'b1, CTL, 32'h3, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, STA, 32'h0, 1'b1, 8'h00, 1'b0);
        chk("ack_status", s_rd, 32'h0000_0102);
        chk("ack_cam_ready", {31'h0, s_ready}, 32'h1);

        // Restart mid-frame at idx 100
        for (int k = 0; k < 100; k++) beat(8'(k), k == 0);
        beat(8'hAA, 1'b1);
        idle_read(FBB);
        chk("restart_fb0", s_rd, 32'h0000_00AA);
        idle_read(STA);
        chk("restart_status", s_rd, 32'h0000_0104);
        beat(8'h55, 1'b0);
        idle_read(FBB + 32'h4);
        chk("restart_idx1", s_rd, 32'h0000_0055);

        // CPU store wins the frame-buffer port
        for (int k = 2; k < 10; k++) beat(8'(k), 1'b0);
        cycle(1'b1, FBB + 32'h8, 32'h1234_5678, 1'b1, 8'h77, 1'b0);
        chk("conflict_ready", {31'h0, s_ready}, 32'h0);
        beat(8'h77, 1'b0);
        chk("conflict_retry", {31'h0, s_ready}, 32'h1);
        idle_read(FBB + 32'h8);
        chk("conflict_cpu", s_rd, 32'h1234_5678);
        idle_read(FBB + 32'd40);
        chk("conflict_pixel", s_rd, 32'h0000_0077);

        // Asynchronous reset in CAPTURE at idx 50
        for (int k = 11; k < 50; k++) beat(8'(k), 1'b0);
        write_enable = 1'b0; addr = STA; cam_valid = 1'b1; cam_sof = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_cam_ready", {31'h0, cam_ready}, 32'h0);
        chk("async_status", read_data, 32'h0);
        model_reset();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            beat(8'h11, 1'b1);
            chk("post_rst_ready", {31'h0, s_ready}, 32'h0);
        end
        idle_read(FBB + 32'd40);
        chk("fb_kept", s_rd, 32'h0000_0077);
        cycle(1'b1, CTL, 32'h1, 1'b0, 8'h00, 1'b0);
        beat(8'h22, 1'b1);
        chk("reenable_ready", {31'h0, s_ready}, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            logic we, v, sof;
            case ($urandom_range(0, 5))
                0, 5: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
                1:    a = FBB + 32'($urandom_range(0, FBW - 1) * 4);
                2:    a = STA;
                3:    a = CTL;
                default: a = $urandom | 32'h8000_0000;
            endcase
            we  = $urandom_range(0, 3) == 0;
            wd  = $urandom;
            if (a == CTL) begin
                wd[0] = $urandom_range(0, 31) != 0;
                wd[1] = $urandom_range(0, 1) == 1;
            end
            v   = $urandom_range(0, 3) != 0;
            sof = $urandom_range(0, 599) == 0;
            cycle(we, a, wd, v, 8'($urandom), sof);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
